// File: rtl/audio_sd_dac.sv
// Stereo PCM to 1-bit audio: per-channel linear interpolation toward each new
// sample, then a first-order sigma-delta modulator. Soft mute ramps to midscale.
`timescale 1ns/1ps

module audio_sd_dac_ch #(
    parameter int IN_W = 6,
    parameter int F    = 6
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            tick,
    input  logic            mute,
    input  logic [IN_W-1:0] audio,
    output logic            dac
);

    localparam int N = IN_W + F;
    localparam logic [IN_W-1:0] MID = IN_W'(1) << (IN_W - 1);

    logic [IN_W-1:0]        tgt;
    logic [IN_W-1:0]        nxt;
    logic [N-1:0]           cur;
    logic [N-1:0]           acc;
    logic signed [IN_W:0]   delta;
    logic [N-1:0]           dext;
    logic [N:0]             sum;

    assign nxt  = mute ? MID : audio;
    assign dext = {{F{delta[IN_W]}}, delta[IN_W-1:0]};
    assign sum  = {1'b0, acc} + {1'b0, cur};

    // cur snaps to the previous target on every tick so ramp error never accumulates
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tgt   <= '0;
            cur   <= '0;
            delta <= '0;
            acc   <= '0;
            dac   <= 1'b0;
        end else begin
            acc <= sum[N-1:0];
            dac <= sum[N];
            if (tick) begin
                tgt   <= nxt;
                cur   <= {tgt, {F{1'b0}}};
                delta <= {1'b0, nxt} - {1'b0, tgt};
            end else begin
                cur <= cur + dext;
            end
        end
    end

endmodule

module audio_sd_dac #(
    parameter int IN_W    = 6,
    parameter int UPD_DIV = 64
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic [IN_W-1:0] audio_l,
    input  logic [IN_W-1:0] audio_r,
    input  logic            mute,
    output logic            dac_l,
    output logic            dac_r
);

    localparam int F = $clog2(UPD_DIV);

    logic [F-1:0] cnt;
    logic         tick;

    assign tick = (cnt == F'(UPD_DIV - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + F'(1);
        end
    end

    audio_sd_dac_ch #(
        .IN_W (IN_W),
        .F    (F)
    ) u_l (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .tick    (tick),
        .mute    (mute),
        .audio   (audio_l),
        .dac     (dac_l)
    );

    audio_sd_dac_ch #(
        .IN_W (IN_W),
        .F    (F)
    ) u_r (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .tick    (tick),
        .mute    (mute),
        .audio   (audio_r),
        .dac     (dac_r)
    );

endmodule
